// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Holds the controller state encoding and the digit-correction constants.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int CORR_THRESH = 8;
  localparam int CORR_SUB    = 3;
  localparam int MAX_DIGIT   = 9;

  // True when a 4-bit field cannot be a decimal digit.
  function automatic logic digit_gt_max(input logic [3:0] d);
    return d > 4'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/done handshake and operand/result bus of the BCD-to-binary converter.
// The requester uses the master modport; the converter uses the slave modport.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start_i;
  logic [4*DIGITS-1:0]   bcd_i;
  logic                  neg_i;
  logic                  busy_o;
  logic                  done_o;
  logic [BIN_W:0]        bin_o;
  logic                  err_o;

  modport master (
    output start_i, bcd_i, neg_i,
    input  busy_o, done_o, bin_o, err_o
  );

  modport slave (
    input  start_i, bcd_i, neg_i,
    output busy_o, done_o, bin_o, err_o
  );
endinterface

// File: rtl/bcd_to_bin_seq_bcd_digit_corr.sv
// One reverse double-dabble correction step for a single BCD digit:
// a digit that reached 8 or more after the right shift gets 3 subtracted.
module bcd_digit_corr
  import conv_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'(CORR_THRESH)) ? (digit_i - 4'(CORR_SUB)) : digit_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift plus
// digit correction per clock, producing a signed two's-complement result.
module bcd_to_bin_seq
  import conv_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic             clk,
  input  logic             rst,
  bcd_to_bin_seq_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t              state_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [BIN_W-1:0]    mag_q;
  logic                neg_q;
  logic                bad_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [BIN_W:0]      bin_q;
  logic                err_q;

  logic [BCD_W-1:0]    shift_bcd;
  logic [BIN_W-1:0]    shift_mag;
  logic [BCD_W-1:0]    corr_bcd;
  logic [DIGITS-1:0]   dig_bad;
  logic                any_bad;
  logic [BIN_W:0]      mag_ext;
  logic [BIN_W:0]      signed_d;

  // The BCD LSB falls into the magnitude MSB on every shift.
  assign shift_bcd = {1'b0, bcd_q[BCD_W-1:1]};
  assign shift_mag = {bcd_q[0], mag_q[BIN_W-1:1]};

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_corr u_corr (
        .digit_i (shift_bcd[gi*4 +: 4]),
        .digit_o (corr_bcd[gi*4 +: 4])
      );
      assign dig_bad[gi] = digit_gt_max(bcd_q[gi*4 +: 4]);
    end
  endgenerate

  assign any_bad  = |dig_bad;
  assign mag_ext  = {1'b0, mag_q};
  // Subtracting from zero makes a negative zero come out as plain zero.
  assign signed_d = neg_q ? ('0 - mag_ext) : mag_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            bcd_q   <= bus.bcd_i;
            neg_q   <= bus.neg_i;
            mag_q   <= '0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (any_bad) begin
            bad_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else begin
            cnt_q   <= CNT_W'(BIN_W);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= corr_bcd;
          mag_q <= shift_mag;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          err_q   <= bad_q;
          bin_q   <= bad_q ? '0 : signed_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.bin_o  = bin_q;
  assign bus.err_o  = err_q;

endmodule
